// File: rtl/handshake_fifo_if.sv
// handshake_fifo_if -- push/pop handshake bundle for handshake_fifo.
//   push side : push_valid_in, data_in (producer -> FIFO), push_grant_out (FIFO -> producer)
//   pop side  : pop_valid_out, data_out (FIFO -> consumer), pop_grant_in (consumer -> FIFO)
//   status    : count_out, number of stored elements 0..DEPTH
// The slave modport is the FIFO side; master is the producer/consumer side.
interface handshake_fifo_if #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
);
    logic                       push_valid_in;
    logic                       push_grant_out;
    logic [DATA_WIDTH-1:0]      data_in;
    logic                       pop_valid_out;
    logic                       pop_grant_in;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [$clog2(DEPTH):0]     count_out;

    modport slave (
        input  push_valid_in, data_in, pop_grant_in,
        output push_grant_out, pop_valid_out, data_out, count_out
    );

    modport master (
        output push_valid_in, data_in, pop_grant_in,
        input  push_grant_out, pop_valid_out, data_out, count_out
    );
endinterface

// File: rtl/handshake_fifo.sv
// handshake_fifo -- first-word fall-through FIFO with valid/grant handshakes.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (pointers and count only)
//   bus   : handshake_fifo_if.slave (push/pop handshakes, data, count)
// Grants and valids are decoded from the registered count only, so there is
// no combinational path from push_valid_in/pop_grant_in to the handshake outputs.
// Payload (including the producer's parity bit) is stored and returned untouched.
module handshake_fifo #(
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    handshake_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q,  count_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic not_full, not_empty, push_fire, pop_fire;

    assign not_full  = (count_q != FULL);
    assign not_empty = (count_q != '0);
    // rst_n gate keeps a push during reset from touching storage.
    assign push_fire = bus.push_valid_in && not_full && rst_n;
    assign pop_fire  = bus.pop_grant_in  && not_empty;

    assign bus.push_grant_out = not_full;
    assign bus.pop_valid_out  = not_empty;
    assign bus.count_out      = count_q;
    // Mask stale (never reset) storage when empty.
    assign bus.data_out       = not_empty ? mem[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural AW-bit overflow is the wrap.
        if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr_q] <= bus.data_in;
    end
endmodule

// File: tb/tb_handshake_fifo.sv
module tb_handshake_fifo;
    localparam int DW = 17;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] mq [$];

    always #5 clk = ~clk;

    handshake_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    handshake_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Drive one cycle of stimulus and advance the queue model across the edge.
    task automatic step(input logic pv, input logic [DW-1:0] d, input logic pg);
        bit do_push, do_pop;
        bus.push_valid_in = pv;
        bus.data_in       = d;
        bus.pop_grant_in  = pg;
        do_push = pv && (mq.size() < DP) && rst_n;
        do_pop  = pg && (mq.size() > 0);
        @(posedge clk);
        if (rst_n) begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        #1;
        bus.push_valid_in = 1'b0;
        bus.pop_grant_in  = 1'b0;
        bus.data_in       = '0;
    endtask

    task automatic test_reset();
        bus.push_valid_in = 1'b1;
        bus.data_in       = 17'h155;
        bus.pop_grant_in  = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_out); end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pop_valid_out); end
        checks++; if (bus.push_grant_out !== 1'b1) begin errors++; $display("FAIL reset_grant: got %b expected 1", bus.push_grant_out); end
        checks++; if (bus.data_out !== 17'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.data_out); end
        bus.push_valid_in = 1'b0;
        bus.pop_grant_in  = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", bus.count_out); end
        mq.delete();
    endtask

    task automatic test_single_push();
        step(1'b1, 17'h00003, 1'b0);
        checks++; if (bus.pop_valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.pop_valid_out); end
        checks++; if (bus.data_out !== 17'h00003) begin errors++; $display("FAIL single_data: got %h expected 00003", bus.data_out); end
        checks++; if (bus.count_out !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count_out); end
        step(1'b0, '0, 1'b1);
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", bus.pop_valid_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DP; i++) step(1'b1, DW'(i), 1'b0);
        checks++; if (bus.count_out !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", bus.count_out); end
        checks++; if (bus.push_grant_out !== 1'b0) begin errors++; $display("FAIL fill_grant: got %b expected 0", bus.push_grant_out); end
        step(1'b1, 17'h1FFFF, 1'b0);
        checks++; if (bus.count_out !== 4'd8) begin errors++; $display("FAIL overfill_count: got %0d expected 8", bus.count_out); end
        for (int i = 1; i <= DP; i++) begin
            checks++;
            if (bus.data_out !== DW'(i)) begin errors++; $display("FAIL fill_order[%0d]: got %h expected %h", i, bus.data_out, DW'(i)); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL fill_empty_valid: got %b expected 0", bus.pop_valid_out); end
        checks++; if (bus.data_out !== 17'h0) begin errors++; $display("FAIL fill_empty_data: got %h expected 0", bus.data_out); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, DW'(17'h10 + i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.data_out !== DW'(17'h10 + i)) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, bus.data_out, DW'(17'h10 + i)); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL wrap_count: got %0d expected 0", bus.count_out); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b1, 17'h0AAAA, 1'b1);
        checks++; if (bus.count_out !== 4'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", bus.count_out); end
        // Two older entries remain ahead of 0AAAA (one left in the simultaneous pop).
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.data_out !== mq[0]) begin errors++; $display("FAIL simul_order[%0d]: got %h expected %h", i, bus.data_out, mq[0]); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b expected 0", bus.pop_valid_out); end
    endtask

    task automatic test_full_pop_push();
        logic [DW-1:0] first;
        for (int i = 0; i < DP; i++) step(1'b1, DW'(17'h200 + i), 1'b0);
        first = mq[0];
        step(1'b1, 17'h1BEEF, 1'b1);
        checks++; if (bus.count_out !== 4'd7) begin errors++; $display("FAIL fullpp_count: got %0d expected 7", bus.count_out); end
        checks++; if (bus.push_grant_out !== 1'b1) begin errors++; $display("FAIL fullpp_grant: got %b expected 1", bus.push_grant_out); end
        checks++; if (bus.data_out === first) begin errors++; $display("FAIL fullpp_head: got %h expected not %h", bus.data_out, first); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (bus.data_out !== DW'(17'h201 + i)) begin errors++; $display("FAIL fullpp_order[%0d]: got %h expected %h", i, bus.data_out, DW'(17'h201 + i)); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL fullpp_empty: got %b expected 0", bus.pop_valid_out); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
        checks++; if (bus.count_out !== 4'd5) begin errors++; $display("FAIL areset_pre_count: got %0d expected 5", bus.count_out); end
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        checks++; if (bus.count_out !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", bus.count_out); end
        checks++; if (bus.pop_valid_out !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", bus.pop_valid_out); end
        checks++; if (bus.data_out !== 17'h0) begin errors++; $display("FAIL areset_data: got %h expected 0", bus.data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 17'h00007, 1'b0);
        checks++; if (bus.data_out !== 17'h00007) begin errors++; $display("FAIL areset_push: got %h expected 00007", bus.data_out); end
        checks++; if (bus.count_out !== 4'd1) begin errors++; $display("FAIL areset_push_count: got %0d expected 1", bus.count_out); end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_d;
        for (int n = 0; n < 600; n++) begin
            exp_d = (mq.size() != 0) ? mq[0] : '0;
            checks++;
            if (bus.count_out !== 4'(mq.size()) || bus.data_out !== exp_d ||
                bus.push_grant_out !== (mq.size() != DP) || bus.pop_valid_out !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL random[%0d]: got cnt=%0d d=%h g=%b v=%b expected cnt=%0d d=%h g=%b v=%b", n,
                         bus.count_out, bus.data_out, bus.push_grant_out, bus.pop_valid_out,
                         mq.size(), exp_d, (mq.size() != DP), (mq.size() != 0));
            end
            // Phase bias so both full and empty boundaries get exercised.
            if ((n / 100) % 2 == 0)
                step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) == 0);
            else
                step($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        bus.push_valid_in = 1'b0;
        bus.pop_grant_in  = 1'b0;
        bus.data_in       = '0;
        test_reset();
        test_single_push();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_full_pop_push();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
